rf_nr1w_clr: RTL and testbench
==============================

RF_NR1W_CLR -- requirements
Module: rf_nr1w_clr

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the data width of every register entry.
REQ-002 Parameter ADDR_W, default 5, SHALL set the address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter NUM_RD, default 2, range 1..8, SHALL set the number of independent read ports.
REQ-004 Parameter ZERO_REG, default 1, SHALL hard-wire entry 0 to zero when 1.
REQ-005 Parameter BYPASS, default 1, SHALL enable same-cycle write-to-read forwarding when 1.
REQ-006 Clock and reset: one clock; reset is synchronous and active-high.
REQ-007 clk  input  1  sole clock; all state updates on its rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 i_rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W].
REQ-010 o_rd_data  output  NUM_RD*DATA_W  packed read data; port k at bits [k*DATA_W +: DATA_W].
REQ-011 i_wr_addr  input  ADDR_W  write address.
REQ-012 i_wr_data  input  DATA_W  write data.
REQ-013 i_wr_en  input  1  write enable.
REQ-014 i_clr  input  1  single-cycle request to clear all entries.
REQ-015 o_busy  output  1  high while a clear sweep is in progress.
REQ-016 o_wr_drop  output  1  combinational; high when i_wr_en is asserted while o_busy is high.

Function
REQ-017 Reads SHALL be combinational (zero latency) from array contents; all NUM_RD ports SHALL be independent, including reads of equal addresses.
REQ-018 In IDLE, when i_wr_en=1, entry i_wr_addr SHALL take i_wr_data at the next rising edge.
REQ-019 When ZERO_REG=1, writes to address 0 SHALL be discarded without asserting o_wr_drop, and any port reading address 0 SHALL return 0.
REQ-020 When BYPASS=1, in IDLE with i_wr_en=1 and i_rd_addr[k]==i_wr_addr (not the zero register), o_rd_data[k] SHALL equal i_wr_data in the same cycle.
REQ-021 When BYPASS=0, such a read SHALL return the old contents until the edge after the write.
REQ-022 FSM states: IDLE and CLEAR; a clear counter of ADDR_W bits SHALL index the entry being cleared.
REQ-023 IDLE -> CLEAR on i_clr=1; the counter loads 0 at the same edge.
REQ-024 In CLEAR, each cycle SHALL write 0 to entry[counter] and increment the counter; at counter==DEPTH-1 the next state SHALL be IDLE; the sweep SHALL last exactly DEPTH cycles.
REQ-025 o_busy SHALL equal 1 exactly when the state is CLEAR.
REQ-026 In CLEAR, user writes SHALL be ignored (o_wr_drop=1), all o_rd_data ports SHALL read 0, and bypass SHALL be inactive.
REQ-027 i_clr asserted during CLEAR SHALL be ignored; the sweep SHALL neither restart nor extend.
REQ-028 A write and i_clr in the same IDLE cycle SHALL perform the write; the following sweep SHALL then erase it.
REQ-029 Counter wrap-around SHALL never be visible; the state leaves CLEAR on the terminal count.

Reset
REQ-030 While rst=1, the state SHALL be CLEAR with the counter held at 0, o_busy=1, and o_rd_data all zero; the array SHALL not be reset directly.
REQ-031 After rst deasserts, the sweep SHALL run DEPTH cycles, then enter IDLE with all entries zero.
REQ-032 rst asserted mid-sweep SHALL reload the counter to 0, restarting the full sweep.
REQ-033 rst SHALL take precedence over i_clr, i_wr_en and all other inputs.

Verification
REQ-034 Reset release, defaults: o_busy=1 for exactly 32 cycles, then 0; all reads of addresses 0..31 return 0.
REQ-035 Write 0xDEADBEEF to addr 7 while port 0 and port 1 read addr 7: both show 0xDEADBEEF in the same cycle (BYPASS=1); with BYPASS=0, both show 0 and then 0xDEADBEEF on the next cycle.
REQ-036 Write 0x12345678 to addr 0 with ZERO_REG=1: o_wr_drop=0; reading addr 0 returns 0.
REQ-037 Fill all entries, pulse i_clr, then write 0xA5A5A5A5 to addr 3 during the sweep: o_wr_drop=1; after 32 cycles every entry reads 0.
REQ-038 Pulse i_clr at sweep cycle 10: the sweep still ends at cycle 32; assert rst at cycle 20: o_busy stays high for 32 cycles after rst deasserts.
REQ-039 With NUM_RD=4 and ADDR_W=3, write distinct values to 8 entries and read all four ports at once on varying addresses: each port returns its own entry; the sweep lasts 8 cycles.

Source files
------------

// File: rtl/rf_nr1w_clr.sv
// Multi-read, single-write register file with a sequential clear sweep.
// Reads are combinational, with optional write forwarding and a hard-wired zero entry.
module rf_nr1w_clr #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic                     i_wr_en,
  input  logic                     i_clr,
  output logic                     o_busy,
  output logic                     o_wr_drop
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clrCnt_q, clrCnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                userWr;
  logic                memWe;
  logic [ADDR_W-1:0]   memWaddr;
  logic [DATA_W-1:0]   memWdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CLEAR;
      clrCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      clrCnt_q <= clrCnt_d;
    end
  end

  // The sweep exits on the terminal count, so the counter wraps back to 0 unseen.
  always_comb begin
    state_d  = state_q;
    clrCnt_d = clrCnt_q;
    case (state_q)
      IDLE: begin
        if (i_clr) begin
          state_d  = CLEAR;
          clrCnt_d = '0;
        end
      end
      CLEAR: begin
        clrCnt_d = clrCnt_q + 1'b1;
        if (clrCnt_q == LAST_IDX) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d  = CLEAR;
        clrCnt_d = '0;
      end
    endcase
  end

  assign o_busy    = (state_q == CLEAR);
  assign o_wr_drop = i_wr_en && o_busy;

  // Writes to the zero register are silently discarded rather than dropped.
  assign userWr = !rst && (state_q == IDLE) && i_wr_en &&
                  !((ZERO_REG != 0) && (i_wr_addr == '0));

  always_comb begin
    memWe    = 1'b0;
    memWaddr = i_wr_addr;
    memWdata = i_wr_data;
    if (!rst && (state_q == CLEAR)) begin
      memWe    = 1'b1;
      memWaddr = clrCnt_q;
      memWdata = '0;
    end else if (userWr) begin
      memWe = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (memWe) begin
      mem_q[memWaddr] <= memWdata;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : gRd
    logic [ADDR_W-1:0] rdAddr;
    logic [DATA_W-1:0] rdVal;

    assign rdAddr = i_rd_addr[k*ADDR_W +: ADDR_W];

    // Reads are masked during reset and the sweep, so no stale entry ever leaks out.
    always_comb begin
      rdVal = mem_q[rdAddr];
      if (rst || (state_q == CLEAR)) begin
        rdVal = '0;
      end else if ((ZERO_REG != 0) && (rdAddr == '0)) begin
        rdVal = '0;
      end else if ((BYPASS != 0) && userWr && (rdAddr == i_wr_addr)) begin
        rdVal = i_wr_data;
      end
    end

    assign o_rd_data[k*DATA_W +: DATA_W] = rdVal;
  end

endmodule

// File: tb/tb_rf_nr1w_clr.sv
// Directed bench for rf_nr1w_clr: default, no-bypass and 4-port/8-entry instances.
module tb_rf_nr1w_clr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [9:0]   rdAddrA;
  logic [63:0]  rdDataA;
  logic [4:0]   wrAddrA;
  logic [31:0]  wrDataA;
  logic         wrEnA, clrA, busyA, dropA;

  logic [9:0]   rdAddrB;
  logic [63:0]  rdDataB;
  logic [4:0]   wrAddrB;
  logic [31:0]  wrDataB;
  logic         wrEnB, clrB, busyB, dropB;

  logic [11:0]  rdAddrC;
  logic [127:0] rdDataC;
  logic [2:0]   wrAddrC;
  logic [31:0]  wrDataC;
  logic         wrEnC, clrC, busyC, dropC;

  int nChecks = 0;
  int nPass   = 0;

  rf_nr1w_clr dutA (
    .clk(clk), .rst(rst), .i_rd_addr(rdAddrA), .o_rd_data(rdDataA),
    .i_wr_addr(wrAddrA), .i_wr_data(wrDataA), .i_wr_en(wrEnA),
    .i_clr(clrA), .o_busy(busyA), .o_wr_drop(dropA)
  );

  rf_nr1w_clr #(.BYPASS(0)) dutB (
    .clk(clk), .rst(rst), .i_rd_addr(rdAddrB), .o_rd_data(rdDataB),
    .i_wr_addr(wrAddrB), .i_wr_data(wrDataB), .i_wr_en(wrEnB),
    .i_clr(clrB), .o_busy(busyB), .o_wr_drop(dropB)
  );

  rf_nr1w_clr #(.NUM_RD(4), .ADDR_W(3)) dutC (
    .clk(clk), .rst(rst), .i_rd_addr(rdAddrC), .o_rd_data(rdDataC),
    .i_wr_addr(wrAddrC), .i_wr_data(wrDataC), .i_wr_en(wrEnC),
    .i_clr(clrC), .o_busy(busyC), .o_wr_drop(dropC)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int bA, bB, bC, cyc, bad;
    rst = 1'b1;
    rdAddrA = '0; wrAddrA = '0; wrDataA = '0; wrEnA = 1'b0; clrA = 1'b0;
    rdAddrB = '0; wrAddrB = '0; wrDataB = '0; wrEnB = 1'b0; clrB = 1'b0;
    rdAddrC = '0; wrAddrC = '0; wrDataC = '0; wrEnC = 1'b0; clrC = 1'b0;
    step();
    step();
    rdAddrA = {5'd3, 5'd9};
    #1;
    nChecks++;
    if (busyA !== 1'b1) $display("[TB] FAIL reset_busy: got %b want 1", busyA);
    else nPass++;
    nChecks++;
    if (rdDataA !== 64'd0) $display("[TB] FAIL reset_rd: got %h want 0", rdDataA);
    else nPass++;

    rst = 1'b0;
    bA = 0; bB = 0; bC = 0; cyc = 0;
    while ((busyA === 1'b1 || busyB === 1'b1 || busyC === 1'b1) && cyc < 200) begin
      if (busyA === 1'b1) bA++;
      if (busyB === 1'b1) bB++;
      if (busyC === 1'b1) bC++;
      cyc++;
      step();
    end
    nChecks++;
    if (bA != 32) $display("[TB] FAIL reset_sweep_a: got %0d cycles want 32", bA);
    else nPass++;
    nChecks++;
    if (bB != 32) $display("[TB] FAIL reset_sweep_b: got %0d cycles want 32", bB);
    else nPass++;
    nChecks++;
    if (bC != 8) $display("[TB] FAIL reset_sweep_c: got %0d cycles want 8", bC);
    else nPass++;

    bad = 0;
    for (int i = 0; i < 32; i++) begin
      rdAddrA = {5'(31 - i), 5'(i)};
      #1;
      if (rdDataA !== 64'd0) bad++;
    end
    nChecks++;
    if (bad != 0) $display("[TB] FAIL reset_zero_reads: got %0d nonzero want 0", bad);
    else nPass++;
  endtask

  task automatic test_bypass();
    wrAddrA = 5'd7; wrDataA = 32'hDEADBEEF; wrEnA = 1'b1;
    rdAddrA = {5'd7, 5'd7};
    #1;
    nChecks++;
    if (rdDataA !== {2{32'hDEADBEEF}}) $display("[TB] FAIL bypass_same_cycle: got %h want %h", rdDataA, {2{32'hDEADBEEF}});
    else nPass++;
    nChecks++;
    if (dropA !== 1'b0) $display("[TB] FAIL bypass_drop: got %b want 0", dropA);
    else nPass++;
    step();
    wrEnA = 1'b0;
    #1;
    nChecks++;
    if (rdDataA !== {2{32'hDEADBEEF}}) $display("[TB] FAIL bypass_stored: got %h want %h", rdDataA, {2{32'hDEADBEEF}});
    else nPass++;
  endtask

  task automatic test_no_bypass();
    wrAddrB = 5'd7; wrDataB = 32'hDEADBEEF; wrEnB = 1'b1;
    rdAddrB = {5'd7, 5'd7};
    #1;
    nChecks++;
    if (rdDataB !== 64'd0) $display("[TB] FAIL nobypass_old: got %h want 0", rdDataB);
    else nPass++;
    step();
    wrEnB = 1'b0;
    #1;
    nChecks++;
    if (rdDataB !== {2{32'hDEADBEEF}}) $display("[TB] FAIL nobypass_next: got %h want %h", rdDataB, {2{32'hDEADBEEF}});
    else nPass++;
  endtask

  task automatic test_zero_reg();
    wrAddrA = 5'd0; wrDataA = 32'h12345678; wrEnA = 1'b1;
    rdAddrA = {5'd0, 5'd0};
    #1;
    nChecks++;
    if (dropA !== 1'b0) $display("[TB] FAIL zero_drop: got %b want 0", dropA);
    else nPass++;
    nChecks++;
    if (rdDataA !== 64'd0) $display("[TB] FAIL zero_bypass: got %h want 0", rdDataA);
    else nPass++;
    step();
    wrEnA = 1'b0;
    #1;
    nChecks++;
    if (rdDataA !== 64'd0) $display("[TB] FAIL zero_stored: got %h want 0", rdDataA);
    else nPass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 10; i <= 12; i++) begin
      wrAddrA = 5'(i); wrDataA = 32'h0B0B0000 + 32'(i); wrEnA = 1'b1;
      step();
    end
    wrEnA = 1'b0;
    rdAddrA = {5'd12, 5'd10};
    #1;
    nChecks++;
    if (rdDataA !== {32'h0B0B000C, 32'h0B0B000A}) $display("[TB] FAIL b2b_rd0: got %h want %h", rdDataA, {32'h0B0B000C, 32'h0B0B000A});
    else nPass++;
    rdAddrA = {5'd10, 5'd11};
    #1;
    nChecks++;
    if (rdDataA !== {32'h0B0B000A, 32'h0B0B000B}) $display("[TB] FAIL b2b_rd1: got %h want %h", rdDataA, {32'h0B0B000A, 32'h0B0B000B});
    else nPass++;
  endtask

  task automatic test_multiport();
    logic [31:0] wrVals [8] = '{32'hC0000000, 32'hC0000111, 32'hC0000222, 32'hC0000333,
                                32'hC0000444, 32'hC0000555, 32'hC0000666, 32'hC0000777};
    logic [31:0] expVals [8] = '{32'h00000000, 32'hC0000111, 32'hC0000222, 32'hC0000333,
                                 32'hC0000444, 32'hC0000555, 32'hC0000666, 32'hC0000777};
    int pat [3][4] = '{'{1, 2, 3, 4}, '{7, 7, 0, 5}, '{6, 3, 3, 1}};
    logic [31:0] got;
    for (int i = 0; i < 8; i++) begin
      wrAddrC = 3'(i); wrDataC = wrVals[i]; wrEnC = 1'b1;
      step();
    end
    wrEnC = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 4; k++) rdAddrC[k*3 +: 3] = 3'(pat[p][k]);
      #1;
      for (int k = 0; k < 4; k++) begin
        got = rdDataC[k*32 +: 32];
        nChecks++;
        if (got !== expVals[pat[p][k]])
          $display("[TB] FAIL multiport_p%0d_k%0d: got %h want %h", p, k, got, expVals[pat[p][k]]);
        else nPass++;
      end
    end
  endtask

  task automatic test_clear_sweep();
    int cyc, bad;
    for (int i = 0; i < 32; i++) begin
      wrAddrA = 5'(i); wrDataA = 32'h10000000 + 32'(i); wrEnA = 1'b1;
      step();
    end
    wrEnA = 1'b0;
    rdAddrA = {5'd31, 5'd5};
    #1;
    nChecks++;
    if (rdDataA !== {32'h1000001F, 32'h10000005}) $display("[TB] FAIL fill_rd: got %h want %h", rdDataA, {32'h1000001F, 32'h10000005});
    else nPass++;

    clrA = 1'b1; wrEnA = 1'b1; wrAddrA = 5'd9; wrDataA = 32'hCAFE0009;
    step();
    clrA = 1'b0; wrEnA = 1'b0;
    cyc = 0;
    while (busyA === 1'b1 && cyc < 100) begin
      clrA = (cyc == 10);
      wrEnA = (cyc == 3);
      wrAddrA = 5'd3; wrDataA = 32'hA5A5A5A5;
      rdAddrA = {5'd9, 5'd3};
      #1;
      if (cyc == 3) begin
        nChecks++;
        if (dropA !== 1'b1) $display("[TB] FAIL sweep_drop: got %b want 1", dropA);
        else nPass++;
        nChecks++;
        if (rdDataA !== 64'd0) $display("[TB] FAIL sweep_rd: got %h want 0", rdDataA);
        else nPass++;
      end
      cyc++;
      step();
    end
    clrA = 1'b0; wrEnA = 1'b0;
    nChecks++;
    if (cyc != 32) $display("[TB] FAIL sweep_len: got %0d cycles want 32", cyc);
    else nPass++;

    bad = 0;
    for (int i = 0; i < 32; i++) begin
      rdAddrA = {5'(i), 5'(31 - i)};
      #1;
      if (rdDataA !== 64'd0) bad++;
    end
    nChecks++;
    if (bad != 0) $display("[TB] FAIL sweep_zero_reads: got %0d nonzero want 0", bad);
    else nPass++;
  endtask

  task automatic test_rst_midsweep();
    int cyc;
    clrA = 1'b1;
    step();
    clrA = 1'b0;
    repeat (20) step();
    nChecks++;
    if (busyA !== 1'b1) $display("[TB] FAIL midsweep_busy: got %b want 1", busyA);
    else nPass++;
    rst = 1'b1;
    step();
    step();
    nChecks++;
    if (busyA !== 1'b1) $display("[TB] FAIL midsweep_rst_busy: got %b want 1", busyA);
    else nPass++;
    rst = 1'b0;
    cyc = 0;
    while (busyA === 1'b1 && cyc < 100) begin
      cyc++;
      step();
    end
    nChecks++;
    if (cyc != 32) $display("[TB] FAIL midsweep_len: got %0d cycles want 32", cyc);
    else nPass++;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_no_bypass();
    test_zero_reg();
    test_back_to_back();
    test_multiport();
    test_clear_sweep();
    test_rst_midsweep();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
